// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises PS2_CLK/PS2_DATA, deframes 11-bit
// device-to-host frames, checks start/parity/stop and queues good bytes in a
// show-ahead FIFO drained by the CPU one byte per rd_en strobe.
module ps2_keyboard_rx #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [7:0]                    data_out,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   // Synchroniser chain; clk_s3_q is the previous synchronised clock level
   logic clk_s1_q, clk_s2_q, clk_s3_q;
   logic dat_s1_q, dat_s2_q;
   logic fall, bit_in;

   // Frame receiver state
   logic [0:0]    state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          push, ferr_set;

   // FIFO state
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full, pop, do_push, ovf_set;

   // Sticky flags
   logic overflow_q, overflow_d;
   logic frame_err_q, frame_err_d;

   // Two-flop synchronisers; reset high so an idle bus yields no fall on release
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign fall   = clk_s3_q & ~clk_s2_q;
   assign bit_in = dat_s2_q;

   // Deframing FSM: start bit, 8 data bits LSB first, parity, stop; idle timeout
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tmo_d    = tmo_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (fall) begin
               if (!bit_in) begin
                  state_d  = ST_RECV;
                  bitcnt_d = 4'd1;
               end else begin
                  ferr_set = 1'b1;
               end
            end
         end
         default: begin
            if (fall) begin
               tmo_d = '0;
               if (bitcnt_q <= 4'd8) begin
                  shift_d  = {bit_in, shift_q[7:1]};
                  bitcnt_d = bitcnt_q + 4'd1;
               end else if (bitcnt_q == 4'd9) begin
                  parity_d = bit_in;
                  bitcnt_d = 4'd10;
               end else begin
                  // Stop bit: odd parity over data+parity and stop must be high
                  if (bit_in && (^{shift_q, parity_q})) begin
                     push = 1'b1;
                  end else begin
                     ferr_set = 1'b1;
                  end
                  state_d  = ST_IDLE;
                  bitcnt_d = '0;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               // Abandon a stalled partial frame silently
               state_d  = ST_IDLE;
               bitcnt_d = '0;
               tmo_d    = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
      endcase
   end

   // Receiver registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tmo_q    <= tmo_d;
      end
   end

   // FIFO control: a pop frees the slot a same-cycle push needs when full
   always_comb begin
      full     = (count_q == CW'(FIFO_DEPTH));
      pop      = rd_en & ~empty_q;
      do_push  = push & (~full | pop);
      ovf_set  = push & full & ~pop;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      empty_d     = (count_d == '0);
      overflow_d  = (overflow_q & ~err_clr) | ovf_set;
      frame_err_d = (frame_err_q & ~err_clr) | ferr_set;
   end

   // FIFO pointers, count and sticky flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Storage array; contents need no reset since reads are gated by empty
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   assign data_out  = empty_q ? 8'h00 : mem[rd_ptr_q];
   assign empty     = empty_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus random frames, with a
// bit-level frame model and byte queue predicting every output each cycle.
module tb_ps2_keyboard_rx;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TMO   = 200;
   localparam int EV_FALL = 0;
   localparam int EV_POP  = 1;
   localparam int EV_CLR  = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data_out;
   logic       empty;
   logic [3:0] count;
   logic       overflow;
   logic       frame_err;

   ps2_keyboard_rx #(
      .FIFO_DEPTH    (DEPTH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd_en    (rd_en),
      .err_clr  (err_clr),
      .data_out (data_out),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int due;
      int kind;
      bit b;
   } ev_t;

   ev_t        ev_q[$];
   logic [7:0] mq[$];
   int         cyc = 0;
   int         mpos = 0;
   int         last_fall = 0;
   logic [7:0] mbyte = 8'h00;
   bit         mpar = 1'b0;
   bit         movf = 1'b0;
   bit         mferr = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   bit         rand_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      ev_q.delete();
      mq.delete();
      mpos  = 0;
      movf  = 1'b0;
      mferr = 1'b0;
   endtask

   task automatic add_ev(input int due, input int kind, input bit b);
      ev_t e;
      e.due  = due;
      e.kind = kind;
      e.b    = b;
      ev_q.push_back(e);
   endtask

   // Apply everything the design sees on the edge numbered cyc
   task automatic model_step();
      bit f = 0, fb = 0, p = 0, c = 0, push = 0, ferr_set = 0, do_pop;
      int pre;
      for (int i = ev_q.size() - 1; i >= 0; i--) begin
         if (ev_q[i].due == cyc) begin
            if (ev_q[i].kind == EV_FALL) begin
               f  = 1'b1;
               fb = ev_q[i].b;
            end else if (ev_q[i].kind == EV_POP) begin
               p = 1'b1;
            end else begin
               c = 1'b1;
            end
            ev_q.delete(i);
         end
      end
      if (f) begin
         if (mpos != 0 && (cyc - last_fall) > int'(TMO)) mpos = 0;
         last_fall = cyc;
         if (mpos == 0) begin
            if (!fb) mpos = 1;
            else ferr_set = 1'b1;
         end else if (mpos <= 8) begin
            mbyte[mpos-1] = fb;
            mpos++;
         end else if (mpos == 9) begin
            mpar = fb;
            mpos = 10;
         end else begin
            if (fb && ((^mbyte) ^ mpar)) push = 1'b1;
            else ferr_set = 1'b1;
            mpos = 0;
         end
      end
      pre    = mq.size();
      do_pop = p && (pre > 0);
      if (push) begin
         if (pre == int'(DEPTH) && !do_pop) movf = 1'b1;
         else mq.push_back(mbyte);
      end
      if (do_pop) void'(mq.pop_front());
      if (c) begin
         movf  = 1'b0;
         mferr = 1'b0;
      end
      if (push && pre == int'(DEPTH) && !do_pop) movf = 1'b1;
      if (ferr_set) mferr = 1'b1;
   endtask

   task automatic drive_bit(input bit b, input bit pop_at_push);
      int lo, hi;
      lo = $urandom_range(15, 30);
      hi = $urandom_range(15, 30);
      @(negedge clock);
      ps2_data = b;
      repeat (hi / 2) @(negedge clock);
      ps2_clk = 1'b0;
      add_ev(cyc + 3, EV_FALL, b);
      if (pop_at_push) begin
         // rd_en lands on the same edge that processes this fall
         repeat (2) @(negedge clock);
         rd_en = 1'b1;
         add_ev(cyc + 1, EV_POP, 1'b0);
         @(negedge clock);
         rd_en = 1'b0;
         repeat (lo - 3) @(negedge clock);
      end else begin
         repeat (lo) @(negedge clock);
      end
      ps2_clk = 1'b1;
      repeat (hi) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit pop_at_push);
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
      drive_bit(~(^b) ^ bad_par, 1'b0);
      drive_bit(~bad_stop, pop_at_push);
      ps2_data = 1'b1;
   endtask

   task automatic rd_pulse();
      @(negedge clock);
      rd_en = 1'b1;
      add_ev(cyc + 1, EV_POP, 1'b0);
      @(negedge clock);
      rd_en = 1'b0;
   endtask

   task automatic clr_pulse();
      @(negedge clock);
      err_clr = 1'b1;
      add_ev(cyc + 1, EV_CLR, 1'b0);
      @(negedge clock);
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      model_clear();
      repeat (3) @(negedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      model_clear();
      fork
         forever begin
            @(posedge clock);
            cyc++;
            if (!reset) model_step();
         end
         forever begin
            @(negedge clock);
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("data_out", 32'(data_out), (mq.size() == 0) ? 32'h0 : 32'(mq[0]));
            chk("overflow", 32'(overflow), 32'(movf));
            chk("frame_err", 32'(frame_err), 32'(mferr));
         end
      join_none

      #1 reset = 1'b1;
      idle(3);
      #1 reset = 1'b0;
      idle(2);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_flags", 32'({overflow, frame_err}), 32'h0);

      // Good frame 0x1C, then pop it
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      chk("good_data", 32'(data_out), 32'h1C);
      chk("good_count", 32'(count), 32'h1);
      chk("good_ferr", 32'(frame_err), 32'h0);
      rd_pulse();
      chk("good_pop_empty", 32'(empty), 32'h1);
      chk("good_pop_data", 32'(data_out), 32'h0);

      // Parity error, then clear
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      chk("par_ferr", 32'(frame_err), 32'h1);
      chk("par_empty", 32'(empty), 32'h1);
      clr_pulse();
      chk("par_clr", 32'(frame_err), 32'h0);

      // Overflow: nine frames, no reads
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
      chk("ovf_count", 32'(count), 32'h8);
      chk("ovf_flag", 32'(overflow), 32'h1);
      for (int i = 1; i <= 8; i++) begin
         chk("ovf_order", 32'(data_out), 32'(i));
         rd_pulse();
      end
      chk("ovf_drained", 32'(empty), 32'h1);
      clr_pulse();

      // Full FIFO with a pop coinciding with the push of 0x0A
      for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
      send_frame(8'h0A, 1'b0, 1'b0, 1'b1);
      chk("fullpop_count", 32'(count), 32'h8);
      chk("fullpop_ovf", 32'(overflow), 32'h0);
      chk("fullpop_head", 32'(data_out), 32'h12);
      for (int i = 0; i < 7; i++) rd_pulse();
      chk("fullpop_last", 32'(data_out), 32'h0A);
      rd_pulse();
      chk("fullpop_empty", 32'(empty), 32'h1);

      // Partial frame abandoned by timeout, then 0xF0
      for (int i = 0; i < 5; i++) drive_bit((i == 0) ? 1'b0 : 1'(i & 1), 1'b0);
      idle(2 * TMO);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      chk("tmo_count", 32'(count), 32'h1);
      chk("tmo_data", 32'(data_out), 32'hF0);
      chk("tmo_ferr", 32'(frame_err), 32'h0);
      rd_pulse();

      // Reset in the middle of a frame, then 0x5A
      for (int i = 0; i < 6; i++) drive_bit((i == 0) ? 1'b0 : 1'(~i & 1), 1'b0);
      do_reset();
      idle(4);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      chk("rstmid_count", 32'(count), 32'h1);
      chk("rstmid_data", 32'(data_out), 32'h5A);
      chk("rstmid_flags", 32'({overflow, frame_err}), 32'h0);

      // Random frames with occasional bad parity/stop and a random reader
      fork
         begin
            for (int n = 0; n < 30; n++) begin
               int r;
               r = $urandom_range(0, 9);
               send_frame(8'($urandom_range(0, 255)), r == 0, r == 1, 1'b0);
               if (r <= 1) idle(2 * TMO + 20);
               else idle($urandom_range(0, 60));
               if ($urandom_range(0, 7) == 0) clr_pulse();
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               idle($urandom_range(50, 1500));
               rd_pulse();
            end
         end
      join
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver with a byte FIFO, sitting between the board's PS2_CLK/PS2_DATA pins and the CPU's memory-mapped input path. It synchronises the slow PS/2 lines into the system clock domain, deframes 11-bit device-to-host frames, validates start, parity and stop bits, and queues good scan-code bytes. The CPU-side load logic drains the queue one byte per read strobe.

## Interface

Parameters:
- FIFO_DEPTH, 8: queue entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: idle clock cycles (1 ms at 50 MHz) after which a partial frame is abandoned.

Ports:
- clock  in  1  system clock (CLK50MHZ domain, shared with cpu).
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS2_CLK pin, asynchronous.
- ps2_data  in  1  raw PS2_DATA pin, asynchronous.
- rd_en  in  1  pop strobe, one byte per cycle high.
- err_clr  in  1  clears the sticky flags.
- data_out  out  8  FIFO head byte (show-ahead); 0x00 when empty.
- empty  out  1  FIFO empty.
- count  out  $clog2(FIFO_DEPTH)+1  bytes queued.
- overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
- frame_err  out  1  sticky: start, parity or stop violation seen.

## Operation

- Input conditioning: two-flop synchroniser on each line, plus a third register on the clock line. fall = prev & ~cur. ps2_data is sampled from its synchronised copy in the same cycle as fall.
- FSM states:
  - IDLE: on fall with data=0, go to RECV with bitcnt=1. On fall with data=1, set frame_err and stay in IDLE.
  - RECV: each fall shifts data LSB-first into an 8-bit shift register (bits 1–8), captures parity (bit 9), then checks stop (bit 10). On the bit-10 fall, return to IDLE.
- Validation on the bit-10 fall: stop==1 and XOR(data[7:0], parity)==1 (odd parity).
  - Pass: push the byte.
  - Fail: set frame_err; no push.
- Timeout: a counter runs in RECV, clears on every fall, and sits at 0 in IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and discards the partial byte. No flag is set.
- FIFO: circular buffer with wr_ptr/rd_ptr and a separate count.
  - Push while full, no pop: byte dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while nonempty and not full: count unchanged.
  - rd_en while empty is ignored; pointers and count are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear on err_clr. If err_clr and a new error occur in the same cycle, the flag ends set (set wins).
- Reset, asynchronous and allowed mid-frame or mid-read, forces:
  - FSM to IDLE, bitcnt=0, timeout counter=0;
  - pointers=0, count=0, empty=1, data_out=0x00;
  - overflow=0, frame_err=0;
  - synchroniser and prev registers to 1 (idle-high bus), so no spurious fall is generated on release.

## Timing

- Latency from a ps2_clk pin fall to the internal fall pulse: 3 clock cycles.
- Push happens on the clock edge that processes the stop-bit fall. empty=0 and count+1 are visible the cycle after that edge.
- Pop happens on the rd_en edge. data_out shows the next entry (or 0x00 if the FIFO is now empty) the following cycle.
- Worst-case throughput: one byte per ~11 PS/2 clocks (10–16.7 kHz), far below the clock rate. The FIFO absorbs CPU service jitter only.
- All outputs are registered, except data_out, which is an asynchronous read of mem[rd_ptr] gated by empty.

## Test plan

- Good frame: PS/2 frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12 kHz bus clock -> empty=0, count=1, data_out=0x1C, frame_err=0. Then one rd_en pulse -> empty=1, data_out=0x00.
- Parity error: 0x1C sent with parity 1 -> frame_err=1, empty stays 1. err_clr pulse -> frame_err=0.
- Overflow: 9 good frames 0x01..0x09 with no reads -> count=8, overflow=1. Eight reads return 0x01..0x08 in order, then empty=1.
- Full plus simultaneous pop: FIFO full, assert rd_en on the push cycle of frame 0x0A -> count stays 8, overflow=0, last entry read out is 0x0A.
- Timeout and reset recovery:
  - Send 5 bits, idle for more than TIMEOUT_CYCLES, then a full frame 0xF0 -> exactly one byte 0xF0 queued.
  - Separately, assert reset at bit 6 of a frame, then send frame 0x5A -> only 0x5A queued, no flags set.
